// File: rtl/wrr_output_scheduler.sv
// Weighted round-robin scheduler for one output port of the 4-port switch.
// Grants are held for a whole packet (until done), with per-requester burst
// quotas taken from a runtime-loadable weight table and a starvation watchdog
// that overrides the weighted order.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant outstanding; a winner is chosen when any req is set
// ST_GRANT   | one requester owns the output until it signals done
// ST_RELEASE | single bubble cycle after done before the next arbitration
module wrr_output_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int WEIGHT_W       = 3,
    parameter int DEFAULT_WEIGHT = 1,
    parameter int STARVE_LIMIT   = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic                         done,
    input  logic                         cfg_load,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_cfg,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         grant_valid,
    output logic [NUM_REQ-1:0]           starve_flag,
    output logic                         busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [NUM_REQ-1:0]                  grant_q, grant_d;
    logic                                grant_valid_q, grant_valid_d;
    logic                                busy_q, busy_d;
    logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [WEIGHT_W-1:0]                 quota_q, quota_d;
    logic [NUM_REQ-1:0][WEIGHT_W-1:0]    weight_q, weight_d;
    logic [NUM_REQ-1:0][CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic [NUM_REQ-1:0]                  starve_flag_q, starve_flag_d;

    logic [NUM_REQ-1:0]                  starve_cand;
    logic [PTR_W-1:0]                    starve_idx;
    logic [PTR_W-1:0]                    rr_idx;
    logic                                rr_found;
    logic                                repeat_ok;
    logic [PTR_W-1:0]                    winner;
    logic                                is_repeat;
    logic [WEIGHT_W-1:0]                 win_weight;
    logic [WEIGHT_W-1:0]                 eff_weight;

    // Lowest-index requester that is both flagged starving and still requesting;
    // the req gate covers the cycle where the registered flag lags a dropped req.
    always_comb begin
        starve_cand = starve_flag_q & req;
        starve_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (starve_cand[i]) begin
                starve_idx = PTR_W'(i);
            end
        end
    end

    // First requesting port scanning circularly from the one after the last winner.
    always_comb begin
        rr_idx   = rr_ptr_q;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!rr_found && req[PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
                rr_found = 1'b1;
                rr_idx   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Winner priority: starving port, then last winner with quota left, then round-robin.
    always_comb begin
        repeat_ok = (quota_q != '0) && req[rr_ptr_q];
        if (|starve_cand) begin
            winner = starve_idx;
        end else if (repeat_ok) begin
            winner = rr_ptr_q;
        end else begin
            winner = rr_idx;
        end
        is_repeat  = (winner == rr_ptr_q) && (quota_q != '0);
        win_weight = weight_q[winner];
        eff_weight = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
    end

    // FSM next state, grant, quota and pointer; weight table loads in any state.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        quota_d  = quota_q;
        weight_d = cfg_load ? weight_cfg : weight_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_GRANT;
                    grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    rr_ptr_d = winner;
                    if (is_repeat) begin
                        quota_d = quota_q - WEIGHT_W'(1);
                    end else begin
                        quota_d = eff_weight - WEIGHT_W'(1);
                    end
                end
            end
            ST_GRANT: begin
                if (done) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        grant_valid_d = |grant_d;
        busy_d        = (state_d != ST_IDLE);
    end

    // Per-requester wait counters, saturating at the starvation limit.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] || grant_q[i]) begin
                starve_cnt_d[i] = '0;
            end else if (starve_cnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_d[i] = starve_cnt_q[i] + CNT_W'(1);
            end else begin
                starve_cnt_d[i] = starve_cnt_q[i];
            end
            starve_flag_d[i] = (starve_cnt_q[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
            quota_q       <= '0;
            weight_q      <= {NUM_REQ{WEIGHT_W'(DEFAULT_WEIGHT)}};
            starve_cnt_q  <= '0;
            starve_flag_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            quota_q       <= quota_d;
            weight_q      <= weight_d;
            starve_cnt_q  <= starve_cnt_d;
            starve_flag_q <= starve_flag_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign starve_flag = starve_flag_q;
    assign busy        = busy_q;

endmodule

// File: doc/wrr_output_scheduler.md
Name: wrr_output_scheduler

Overview:
- Per-output-port scheduler for the 4-port switch; one instance sits in front of each output port.
- Shares the output port between the four input ports' FIFO read paths using weighted round-robin.
- Grants are packet-granular: a grant is held until the granted input port signals the end of its packet transfer.
- Adds per-requester burst quotas, a starvation watchdog and a runtime-loadable weight table; replaces plain round-robin where QoS weighting is required.

Parameters:
- NUM_REQ, 4, number of requesting input ports (fixed at 4 for this switch).
- WEIGHT_W, 3, width of each per-requester weight / quota field.
- DEFAULT_WEIGHT, 1, weight loaded into every requester at reset.
- STARVE_LIMIT, 64, waiting cycles after which a requester is flagged as starving.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-input request: a packet targeting this output is at the FIFO head.
- done  in  1  the granted port's packet transfer completes this cycle; ignored when grant_valid=0.
- cfg_load  in  1  one-cycle strobe: load weight_cfg into the weight table.
- weight_cfg  in  NUM_REQ*WEIGHT_W  weight fields; requester i uses bits [i*WEIGHT_W +: WEIGHT_W].
- grant  out  NUM_REQ  one-hot grant, registered.
- grant_valid  out  1  OR of grant, registered.
- starve_flag  out  NUM_REQ  requester i has waited STARVE_LIMIT cycles or more.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - grant=0, grant_valid=0, starve_flag=0, busy=0.
  - FSM=IDLE, rr_ptr=NUM_REQ-1 (so requester 0 is considered first).
  - All weights=DEFAULT_WEIGHT, quota=0.
  - Reset asserted mid-grant drops grant at that same edge; no done is required.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE, no req: stay in IDLE.
- IDLE, any req bit set: select a winner; at the next edge grant=onehot(winner), grant_valid=1, FSM=GRANT. Latency from req to grant is 1 cycle.
- Winner selection (combinational, evaluated in IDLE only):
  - If any starve_flag bit is set: the lowest-index starving requester wins.
  - Else, if the last winner still has quota>0 and its req is set: it wins again.
  - Else: the first set req bit scanning circularly from rr_ptr+1.
- Quota and pointer update on selection:
  - New winner (different requester, or quota exhausted): quota <= eff_weight(winner)-1 and rr_ptr <= winner.
  - Repeat winner: quota <= quota-1.
  - eff_weight = weight, except weight 0 is treated as 1.
- GRANT:
  - Grant held stable regardless of req changes; a requester that drops req mid-packet keeps the grant.
  - done=1: at the next edge grant=0, grant_valid=0, FSM=RELEASE.
- RELEASE: one mandatory idle bubble; next edge FSM=IDLE. Back-to-back packets therefore see a gap of 2 cycles from done to the next grant.
- Starvation counter, one per requester:
  - Increments while req[i]=1 and grant[i]=0; saturates at STARVE_LIMIT.
  - Cleared when req[i]=0 or grant[i]=1.
  - starve_flag[i] = (counter == STARVE_LIMIT), registered.
- cfg_load:
  - The weight table updates at the next edge in any state.
  - The active quota counter is not rewritten; new weights apply at the next new-winner selection.
  - cfg_load in the same cycle as a selection: the selection uses the old weights.
- done while grant_valid=0: ignored, no state change.
- Invariants:
  - grant is never multi-hot.
  - grant_valid == |grant.
  - busy == (FSM != IDLE).

Test Plan:
- Reset then req=4'b0001 from cycle 0 -> grant=4'b0001 in cycle 1; done in cycle 5 -> grant=0 in cycle 6, busy=0 in cycle 7.
- All weights=1, req=4'b1111 held, done pulsed once per grant -> grant order 0,1,2,3,0, with exactly 2 idle cycles between grants.
- Weights {w0=3, w1=1, w2=1, w3=1}, req=4'b1111 held -> sequence 0,0,0,1,2,3,0,0,0.
- req=4'b0011, requester 0 granted with no done for 70 cycles -> starve_flag[1]=1 at cycle 65 after req[1] was first seen waiting; after done, requester 1 wins even if rr_ptr favours another requester.
- Weight field programmed to 0 for requester 2, req=4'b0100 -> one packet per selection (weight treated as 1); cfg_load pulsed mid-grant -> current quota unchanged, new weight applies at the next new winner.
- rst_n=0 asserted while grant=4'b1000 -> grant=0 and starve_flag=0 at that same edge; rr_ptr restarts so requester 0 is considered first.
